// File: rtl/sfft_pkg.sv
// Shared types and constants for the sFFT frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sfft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } sfft_state_t;

    localparam int FRAME_CNT_W = 16;

    // Number of FFT points for a given log2 buffer size.
    function automatic int nfft(input int size_buffer);
        return 1 << size_buffer;
    endfunction

endpackage

// File: rtl/sfft_drain_watchdog.sv
// Counts DRAIN cycles and flags a drain that never completes.
// Latency: timeout is combinational on the cycle the count reaches TIMEOUT-1.
// Backpressure: none; count saturates at TIMEOUT-1 until cleared.
module sfft_drain_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Cycle counter: cleared outside DRAIN, holds at the terminal value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = enable && (count == LAST);

endmodule

// File: rtl/sfft_frame_sequencer.sv
// Sequences one FFT frame at a time into the sFFT interconnect (fill, drain odd half, flush).
// Latency: data/valid/index are combinational pass-through; frame_done is one clock after completion.
// Backpressure: s_ready follows fft_ready in FILL only; upstream is held off in IDLE, DRAIN and FLUSH.
module sfft_frame_sequencer
    import sfft_pkg::*;
#(
    parameter int SIZE_BUFFER   = 3,
    parameter int DATA_FFT_SIZE = 16,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     abort,
    input  logic [DATA_FFT_SIZE-1:0] s_data_i,
    input  logic [DATA_FFT_SIZE-1:0] s_data_q,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     fft_ready,
    output logic [DATA_FFT_SIZE-1:0] ic_data_i,
    output logic [DATA_FFT_SIZE-1:0] ic_data_q,
    output logic                     ic_valid,
    output logic [SIZE_BUFFER:0]     ic_counter_data,
    output logic                     ic_fft_wayt_data,
    input  logic                     ic_second_done_n,
    output logic                     ic_reset,
    output logic                     frame_start,
    output logic                     frame_done,
    output logic [FRAME_CNT_W-1:0]   frame_count,
    output logic                     drain_error,
    output logic                     busy
);

    localparam int NFFT = nfft(SIZE_BUFFER);
    localparam logic [SIZE_BUFFER:0] LAST_IDX = (SIZE_BUFFER + 1)'(NFFT - 1);

    sfft_state_t          state;
    sfft_state_t          state_nxt;
    logic [SIZE_BUFFER:0] index;
    logic                 in_fill;
    logic                 in_drain;
    logic                 transfer;
    logic                 drain_done;
    logic                 frame_complete;
    logic                 drain_timeout;

    assign in_fill        = (state == ST_FILL);
    assign in_drain       = (state == ST_DRAIN);
    assign s_ready        = in_fill & fft_ready;
    assign transfer       = s_valid & s_ready;
    assign ic_valid       = transfer;
    assign ic_data_i      = in_fill ? s_data_i : '0;
    assign ic_data_q      = in_fill ? s_data_q : '0;
    assign ic_counter_data = index;
    assign ic_fft_wayt_data = in_drain & fft_ready;
    assign frame_start    = transfer & (index == '0);
    assign busy           = (state != ST_IDLE);

    // A completion seen together with abort is discarded.
    assign drain_done     = in_drain & ~ic_second_done_n;
    assign frame_complete = drain_done & ~abort;

    sfft_drain_watchdog #(
        .TIMEOUT (DRAIN_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (~in_drain),
        .enable  (in_drain),
        .timeout (drain_timeout)
    );

    // Next-state decode: abort beats completion, completion beats timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable && !ic_reset) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (abort)                               state_nxt = ST_FLUSH;
                else if (transfer && index == LAST_IDX)  state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort)              state_nxt = ST_FLUSH;
                else if (drain_done)    state_nxt = enable ? ST_FILL : ST_IDLE;
                else if (drain_timeout) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, interconnect reset (high exactly while in FLUSH) and sample index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ic_reset <= 1'b1;
            index    <= '0;
        end else begin
            state    <= state_nxt;
            ic_reset <= (state_nxt == ST_FLUSH);
            if (state == ST_FLUSH) begin
                index <= '0;
            end else if (transfer) begin
                index <= (index == LAST_IDX) ? '0 : index + 1'b1;
            end
        end
    end

    // Frame completion pulse, completed-frame counter and sticky drain error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done  <= 1'b0;
            frame_count <= '0;
            drain_error <= 1'b0;
        end else begin
            frame_done  <= frame_complete;
            frame_count <= frame_count + FRAME_CNT_W'(frame_complete);
            if (abort) begin
                drain_error <= 1'b0;
            end else if (drain_timeout && !drain_done) begin
                drain_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sfft_frame_sequencer.sv
module tb_sfft_frame_sequencer;

    localparam int NFFT = 8;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        abort;
    logic [15:0] s_data_i;
    logic [15:0] s_data_q;
    logic        s_valid;
    logic        s_ready;
    logic        fft_ready;
    logic [15:0] ic_data_i;
    logic [15:0] ic_data_q;
    logic        ic_valid;
    logic [3:0]  ic_counter_data;
    logic        ic_fft_wayt_data;
    logic        ic_second_done_n;
    logic        ic_reset;
    logic        frame_start;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        drain_error;
    logic        busy;

    sfft_frame_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .abort            (abort),
        .s_data_i         (s_data_i),
        .s_data_q         (s_data_q),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .fft_ready        (fft_ready),
        .ic_data_i        (ic_data_i),
        .ic_data_q        (ic_data_q),
        .ic_valid         (ic_valid),
        .ic_counter_data  (ic_counter_data),
        .ic_fft_wayt_data (ic_fft_wayt_data),
        .ic_second_done_n (ic_second_done_n),
        .ic_reset         (ic_reset),
        .frame_start      (frame_start),
        .frame_done       (frame_done),
        .frame_count      (frame_count),
        .drain_error      (drain_error),
        .busy             (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard of interconnect output words {i,q} in expected order.
    logic [31:0] exp_q[$];
    logic [31:0] odd_q[$];

    int cyc = 0;
    int exp_idx = 0;
    int sent = 0;
    bit term_pending = 0;
    bit low_pending = 0;
    bit ic_hang = 0;
    bit chk_rdy = 0;
    bit chk_spacing = 0;
    int last_start = -1;
    int wayt_cycles = 0;
    int done_pulses = 0;
    int ic_reset_pulses = 0;
    int exp_frames = 0;
    bit rdy_toggle = 0;

    function automatic logic [31:0] sval(input int base, input int k);
        logic [15:0] i_v;
        logic [15:0] q_v;
        i_v = 16'(base + k);
        q_v = 16'hFFFF - i_v;
        return {i_v, q_v};
    endfunction

    task automatic emit(input logic [31:0] v);
        if (exp_q.size() == 0) chk("sb_unexpected_output", v, 32'hFFFF_FFFF);
        else chk("output_order", v, exp_q.pop_front());
    endtask

    // Interconnect model and output monitor, evaluated mid-cycle.
    initial begin
        bit just_full;
        ic_second_done_n = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (ic_reset) begin
                odd_q.delete();
                sent = 0;
                term_pending = 0;
                low_pending = 0;
                exp_idx = 0;
                ic_second_done_n = 1'b1;
                if (!reset) ic_reset_pulses++;
            end else begin
                if (ic_fft_wayt_data) wayt_cycles++;
                if (frame_done) done_pulses++;
                if (chk_rdy && !fft_ready)
                    chk("no_xfer_when_not_ready", {30'b0, ic_valid, ic_fft_wayt_data}, 32'd0);
                if (ic_valid) begin
                    chk("counter_data", 32'(ic_counter_data), 32'(exp_idx));
                    chk("frame_start", 32'(frame_start), 32'(exp_idx == 0));
                    if (frame_start) begin
                        if (chk_spacing && last_start >= 0)
                            chk("frame_start_spacing", 32'(cyc - last_start), 32'd14);
                        last_start = cyc;
                    end
                    if (exp_idx % 2 == 0) emit({ic_data_i, ic_data_q});
                    else odd_q.push_back({ic_data_i, ic_data_q});
                    exp_idx = (exp_idx + 1) % NFFT;
                end
                just_full = 0;
                if (ic_fft_wayt_data && sent < NFFT / 2) begin
                    if (odd_q.size() == 0) chk("odd_buffer_nonempty", 32'd0, 32'd1);
                    else emit(odd_q.pop_front());
                    sent++;
                    if (sent == NFFT / 2) just_full = 1;
                end
                if (low_pending) begin
                    ic_second_done_n = 1'b0;
                    low_pending = 0;
                    sent = 0;
                end else begin
                    ic_second_done_n = 1'b1;
                    if (term_pending) begin
                        term_pending = 0;
                        low_pending = !ic_hang;
                    end
                end
                if (just_full) term_pending = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_toggle) fft_ready = ~fft_ready;
    endtask

    // Present samples of one frame; stops before sample stop_at when stop_at >= 0.
    task automatic send_frame(input int base, input int drop_at, input int stop_at);
        bit acc;
        int t;
        for (int k = 0; k < NFFT; k += 2) exp_q.push_back(sval(base, k));
        for (int k = 1; k < NFFT; k += 2) exp_q.push_back(sval(base, k));
        for (int k = 0; k < NFFT; k++) begin
            if (k == stop_at) return;
            s_valid = 1'b1;
            {s_data_i, s_data_q} = sval(base, k);
            t = 0;
            forever begin
                @(negedge clk);
                acc = s_ready;
                tick();
                if (acc) break;
                t++;
                if (t > 200) begin
                    chk("transfer_wait_expired", 32'd0, 32'd1);
                    return;
                end
            end
            if (k == drop_at) enable = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (frame_done !== 1'b1 && t < 300) begin
            tick();
            t++;
        end
        chk("frame_done_seen", 32'(frame_done), 32'd1);
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_ic_reset"}, 32'(ic_reset), 32'd1);
        chk({pfx, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({pfx, "_frame_count"}, 32'(frame_count), 32'd0);
        chk({pfx, "_drain_error"}, 32'(drain_error), 32'd0);
        chk({pfx, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({pfx, "_ic_valid"}, 32'(ic_valid), 32'd0);
        chk({pfx, "_counter"}, 32'(ic_counter_data), 32'd0);
        chk({pfx, "_wayt"}, 32'(ic_fft_wayt_data), 32'd0);
        chk({pfx, "_data"}, {ic_data_i, ic_data_q}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        abort = 1'b0;
        s_valid = 1'b0;
        s_data_i = '0;
        s_data_q = '0;
        fft_ready = 1'b1;
        #1;
        check_reset_values("rst");
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("release_ic_reset_hold", 32'(ic_reset), 32'd1);
        tick();
        chk("release_ic_reset_low", 32'(ic_reset), 32'd0);

        // Single frame, fft_ready held high.
        enable = 1'b1;
        wayt_cycles = 0;
        done_pulses = 0;
        send_frame(0, -1, -1);
        s_valid = 1'b0;
        wait_done();
        exp_frames++;
        tick();
        tick();
        chk("single_frame_count", 32'(frame_count), 32'(exp_frames));
        chk("single_drain_cycles", 32'(wayt_cycles), 32'd6);
        chk("single_done_pulses", 32'(done_pulses), 32'd1);
        chk("single_sb_empty", 32'(exp_q.size()), 32'd0);

        // Five back-to-back frames with s_valid held high.
        done_pulses = 0;
        last_start = -1;
        chk_spacing = 1;
        for (int f = 0; f < 5; f++) send_frame(16 * (f + 1), -1, -1);
        s_valid = 1'b0;
        wait_done();
        exp_frames += 5;
        tick();
        tick();
        chk_spacing = 0;
        chk("b2b_frame_count", 32'(frame_count), 32'(exp_frames));
        chk("b2b_done_pulses", 32'(done_pulses), 32'd5);
        chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

        // fft_ready toggling 1010 during FILL and DRAIN.
        rdy_toggle = 1;
        chk_rdy = 1;
        send_frame(256, -1, -1);
        s_valid = 1'b0;
        wait_done();
        exp_frames++;
        rdy_toggle = 0;
        chk_rdy = 0;
        fft_ready = 1'b1;
        tick();
        chk("toggle_frame_count", 32'(frame_count), 32'(exp_frames));
        chk("toggle_sb_empty", 32'(exp_q.size()), 32'd0);

        // Drain never completes: timeout, flush, abort clears error.
        ic_hang = 1;
        wayt_cycles = 0;
        ic_reset_pulses = 0;
        send_frame(512, -1, -1);
        s_valid = 1'b0;
        enable = 1'b0;
        begin
            int t;
            t = 0;
            while (drain_error !== 1'b1 && t < 300) begin
                tick();
                t++;
            end
        end
        chk("timeout_error_set", 32'(drain_error), 32'd1);
        chk("timeout_drain_cycles", 32'(wayt_cycles), 32'd64);
        chk("timeout_ic_reset_high", 32'(ic_reset), 32'd1);
        chk("timeout_busy_flush", 32'(busy), 32'd1);
        tick();
        chk("timeout_ic_reset_low", 32'(ic_reset), 32'd0);
        chk("timeout_idle", 32'(busy), 32'd0);
        tick();
        tick();
        chk("timeout_still_idle", 32'(busy), 32'd0);
        chk("timeout_ic_reset_pulses", 32'(ic_reset_pulses), 32'd1);
        chk("timeout_error_sticky", 32'(drain_error), 32'd1);
        chk("timeout_frame_count", 32'(frame_count), 32'(exp_frames));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_clears_error", 32'(drain_error), 32'd0);
        ic_hang = 0;
        exp_q.delete();

        // enable dropped at index 3: frame completes, then IDLE.
        enable = 1'b1;
        send_frame(768, 3, -1);
        wait_done();
        exp_frames++;
        tick();
        tick();
        chk("endrop_frame_count", 32'(frame_count), 32'(exp_frames));
        chk("endrop_idle", 32'(busy), 32'd0);
        chk("endrop_s_ready", 32'(s_ready), 32'd0);
        chk("endrop_no_valid", 32'(ic_valid), 32'd0);
        chk("endrop_sb_empty", 32'(exp_q.size()), 32'd0);
        s_valid = 1'b0;

        // abort in FILL flushes and the next frame restarts at index 0.
        enable = 1'b1;
        send_frame(1024, -1, 3);
        s_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_fill_ic_reset", 32'(ic_reset), 32'd1);
        chk("abort_fill_count", 32'(frame_count), 32'(exp_frames));
        exp_q.delete();
        send_frame(1280, -1, -1);
        s_valid = 1'b0;
        wait_done();
        exp_frames++;
        chk("abort_next_frame_count", 32'(frame_count), 32'(exp_frames));

        // Async reset mid-frame at index 5.
        send_frame(1536, -1, 5);
        chk("prereset_index", 32'(ic_counter_data), 32'd5);
        reset = 1'b1;
        #1;
        check_reset_values("async");
        exp_q.delete();
        s_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("async_release_ic_reset", 32'(ic_reset), 32'd1);
        tick();
        chk("async_first_clk_ic_reset", 32'(ic_reset), 32'd0);
        chk("async_first_clk_idle", 32'(busy), 32'd0);
        tick();
        chk("async_second_clk_fill", 32'(busy), 32'd1);
        send_frame(1792, -1, -1);
        s_valid = 1'b0;
        wait_done();
        tick();
        chk("async_next_frame_count", 32'(frame_count), 32'd1);
        chk("async_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
